// File: rtl/ascii_to_baudot_tx_if.sv
// ascii_to_baudot_tx_if
//   Groups the serial lines and status pulses of the ASCII-to-Baudot
//   transmitter so that the design and its environment share one bundle.
//
//   Signals:
//     ascii_rx    - ASCII 8N1 serial line into the converter (idle high)
//     baudot_tx   - Baudot serial line out of the converter (idle high, mark)
//     busy        - a Baudot frame is on the line or codes are still queued
//     ascii_valid - one-cycle pulse per correctly framed ASCII byte
//     frame_err   - one-cycle pulse when an ASCII stop bit samples low
//     dropped     - one-cycle pulse when a received byte is not queued
//
//   Signalling: there is no back-pressure anywhere on this bundle. Each
//   status output is a single-cycle strobe that is asserted for exactly one
//   clk cycle per event and is never held; the observer must sample it every
//   cycle. busy is a level.
//
//   Modports: slave = the converter, master = whatever drives/observes it.

interface ascii_to_baudot_tx_if;
    logic ascii_rx;
    logic baudot_tx;
    logic busy;
    logic ascii_valid;
    logic frame_err;
    logic dropped;

    modport master (
        output ascii_rx,
        input  baudot_tx,
        input  busy,
        input  ascii_valid,
        input  frame_err,
        input  dropped
    );

    modport slave (
        input  ascii_rx,
        output baudot_tx,
        output busy,
        output ascii_valid,
        output frame_err,
        output dropped
    );
endinterface

// File: rtl/ascii_to_baudot_tx.sv
// ascii_to_baudot_tx
//   Receives 8N1 ASCII serial, translates each byte to a 5-bit ITA2 (US)
//   code and retransmits it as Baudot serial frames, inserting LTRS (0x1F)
//   or FIGS (0x1B) shift frames whenever the required shift changes. A
//   4-entry code FIFO absorbs the extra time taken by shift frames.
//
//   Ports:
//     clk           - single clock
//     reset         - synchronous, active-high
//     bus           - ascii_to_baudot_tx_if.slave (serial lines + status)
//     rx_state_dbg  - current ASCII receive FSM state
//     tx_state_dbg  - current Baudot transmit FSM state
//     cur_shift_dbg - shift state the remote printer is believed to be in
//
//   Parameters:
//     CLKS_PER_BIT        - clk cycles per ASCII bit (>= 4)
//     BAUDOT_CLKS_PER_BIT - clk cycles per Baudot bit (>= 2)
//     BAUDOT_STOP_BITS    - Baudot stop bits per frame (1..3)
//
//   Build option:
//     UNSHIFT_ON_SPACE_EN - when defined, sending a space marks the shift
//                           state as LTRS, matching unshift-on-space printers.

module ascii_to_baudot_tx #(
    parameter int CLKS_PER_BIT        = 16,
    parameter int BAUDOT_CLKS_PER_BIT = 32,
    parameter int BAUDOT_STOP_BITS    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    ascii_to_baudot_tx_if.slave        bus,
    output logic [1:0]                 rx_state_dbg,
    output logic [1:0]                 tx_state_dbg,
    output logic [1:0]                 cur_shift_dbg
);

    localparam int RX_CW  = $clog2(CLKS_PER_BIT);
    localparam int TX_CW  = (BAUDOT_CLKS_PER_BIT > 2) ? $clog2(BAUDOT_CLKS_PER_BIT) : 1;
    localparam int NBITS  = 6 + BAUDOT_STOP_BITS;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_CHAR} tx_state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_LTRS, CLS_FIGS, CLS_BOTH} cls_t;
    typedef enum logic [1:0] {SH_UNKNOWN, SH_LTRS, SH_FIGS} shift_t;

    typedef struct packed {
        cls_t       cls;
        logic [4:0] code;
    } entry_t;

    // ASCII -> ITA2 (US). Code bit 0 is ITA2 bit 1, the first bit sent.
    function automatic entry_t translate(input logic [7:0] ch);
        logic [7:0] c;
        entry_t     e;
        c = ch;
        if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
        e = '{CLS_NONE, 5'h00};
        case (c)
            8'h41: e = '{CLS_LTRS, 5'h03}; // A
            8'h42: e = '{CLS_LTRS, 5'h19}; // B
            8'h43: e = '{CLS_LTRS, 5'h0E}; // C
            8'h44: e = '{CLS_LTRS, 5'h09}; // D
            8'h45: e = '{CLS_LTRS, 5'h01}; // E
            8'h46: e = '{CLS_LTRS, 5'h0D}; // F
            8'h47: e = '{CLS_LTRS, 5'h1A}; // G
            8'h48: e = '{CLS_LTRS, 5'h14}; // H
            8'h49: e = '{CLS_LTRS, 5'h06}; // I
            8'h4A: e = '{CLS_LTRS, 5'h0B}; // J
            8'h4B: e = '{CLS_LTRS, 5'h0F}; // K
            8'h4C: e = '{CLS_LTRS, 5'h12}; // L
            8'h4D: e = '{CLS_LTRS, 5'h1C}; // M
            8'h4E: e = '{CLS_LTRS, 5'h0C}; // N
            8'h4F: e = '{CLS_LTRS, 5'h18}; // O
            8'h50: e = '{CLS_LTRS, 5'h16}; // P
            8'h51: e = '{CLS_LTRS, 5'h17}; // Q
            8'h52: e = '{CLS_LTRS, 5'h0A}; // R
            8'h53: e = '{CLS_LTRS, 5'h05}; // S
            8'h54: e = '{CLS_LTRS, 5'h10}; // T
            8'h55: e = '{CLS_LTRS, 5'h07}; // U
            8'h56: e = '{CLS_LTRS, 5'h1E}; // V
            8'h57: e = '{CLS_LTRS, 5'h13}; // W
            8'h58: e = '{CLS_LTRS, 5'h1D}; // X
            8'h59: e = '{CLS_LTRS, 5'h15}; // Y
            8'h5A: e = '{CLS_LTRS, 5'h11}; // Z
            8'h30: e = '{CLS_FIGS, 5'h16}; // 0
            8'h31: e = '{CLS_FIGS, 5'h17}; // 1
            8'h32: e = '{CLS_FIGS, 5'h13}; // 2
            8'h33: e = '{CLS_FIGS, 5'h01}; // 3
            8'h34: e = '{CLS_FIGS, 5'h0A}; // 4
            8'h35: e = '{CLS_FIGS, 5'h10}; // 5
            8'h36: e = '{CLS_FIGS, 5'h15}; // 6
            8'h37: e = '{CLS_FIGS, 5'h07}; // 7
            8'h38: e = '{CLS_FIGS, 5'h06}; // 8
            8'h39: e = '{CLS_FIGS, 5'h18}; // 9
            8'h2D: e = '{CLS_FIGS, 5'h03}; // -
            8'h3F: e = '{CLS_FIGS, 5'h19}; // ?
            8'h3A: e = '{CLS_FIGS, 5'h0E}; // :
            8'h24: e = '{CLS_FIGS, 5'h09}; // $
            8'h21: e = '{CLS_FIGS, 5'h0D}; // !
            8'h26: e = '{CLS_FIGS, 5'h1A}; // &
            8'h23: e = '{CLS_FIGS, 5'h14}; // #
            8'h27: e = '{CLS_FIGS, 5'h0B}; // '
            8'h28: e = '{CLS_FIGS, 5'h0F}; // (
            8'h29: e = '{CLS_FIGS, 5'h12}; // )
            8'h2E: e = '{CLS_FIGS, 5'h1C}; // .
            8'h2C: e = '{CLS_FIGS, 5'h0C}; // ,
            8'h3B: e = '{CLS_FIGS, 5'h1E}; // ;
            8'h2F: e = '{CLS_FIGS, 5'h1D}; // /
            8'h22: e = '{CLS_FIGS, 5'h11}; // "
            8'h07: e = '{CLS_FIGS, 5'h05}; // BEL
            8'h20: e = '{CLS_BOTH, 5'h04}; // space
            8'h0D: e = '{CLS_BOTH, 5'h08}; // CR
            8'h0A: e = '{CLS_BOTH, 5'h02}; // LF
            8'h00: e = '{CLS_BOTH, 5'h00}; // NUL
            default: e = '{CLS_NONE, 5'h00};
        endcase
        return e;
    endfunction

    // ---------------- ASCII receiver ----------------
    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state, rx_state_n;
    logic [RX_CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             rx_ok_n, rx_err_n;
    logic             ascii_valid_q, frame_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_byte       <= '0;
            ascii_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_meta       <= bus.ascii_rx;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            rx_state      <= rx_state_n;
            rx_cnt        <= rx_cnt_n;
            rx_bit        <= rx_bit_n;
            rx_byte       <= rx_byte_n;
            ascii_valid_q <= rx_ok_n;
            frame_err_q   <= rx_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + RX_CW'(1);
        rx_bit_n   = rx_bit;
        rx_byte_n  = rx_byte;
        rx_ok_n    = 1'b0;
        rx_err_n   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (rx_prev && !rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                // Mid start bit: a high line means the edge was a glitch.
                if (rx_cnt == RX_CW'(CLKS_PER_BIT / 2 - 1)) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == RX_CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_n  = '0;
                    rx_byte_n = {rx_sync, rx_byte[7:1]};
                    rx_bit_n  = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == RX_CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    rx_ok_n    = rx_sync;
                    rx_err_n   = !rx_sync;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- Code FIFO ----------------
    entry_t     rx_entry;
    entry_t     fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_cnt;
    logic       push, pop, dropped_q;
    entry_t     head;

    assign rx_entry = translate(rx_byte);
    assign head     = fifo_mem[rd_ptr];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = ascii_valid_q && (rx_entry.cls != CLS_NONE) &&
                      ((fifo_cnt != 3'd4) || pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            dropped_q <= ascii_valid_q && !push;
        end
    end

    // ---------------- Baudot transmitter ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [TX_CW-1:0] tx_clk, tx_clk_n;
    logic [3:0]       tx_idx, tx_idx_n;
    logic [4:0]       tx_data, tx_data_n;
    logic [4:0]       tx_char, tx_char_n;
    shift_t           cur_shift, cur_shift_n;
    logic             baudot_q, line_n;
    logic [15:0]      frame_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_clk    <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
            tx_char   <= '0;
            cur_shift <= SH_UNKNOWN;
            baudot_q  <= 1'b1;
        end else begin
            tx_state  <= tx_state_n;
            tx_clk    <= tx_clk_n;
            tx_idx    <= tx_idx_n;
            tx_data   <= tx_data_n;
            tx_char   <= tx_char_n;
            cur_shift <= cur_shift_n;
            baudot_q  <= line_n;
        end
    end

    always_comb begin
        tx_state_n  = tx_state;
        tx_clk_n    = tx_clk + TX_CW'(1);
        tx_idx_n    = tx_idx;
        tx_data_n   = tx_data;
        tx_char_n   = tx_char;
        cur_shift_n = cur_shift;
        pop         = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_clk_n = '0;
                tx_idx_n = '0;
                if (fifo_cnt != 3'd0) begin
                    pop = 1'b1;
                    if ((head.cls == CLS_LTRS && cur_shift != SH_LTRS) ||
                        (head.cls == CLS_FIGS && cur_shift != SH_FIGS)) begin
                        tx_state_n  = TX_SHIFT;
                        tx_data_n   = (head.cls == CLS_LTRS) ? 5'h1F : 5'h1B;
                        cur_shift_n = (head.cls == CLS_LTRS) ? SH_LTRS : SH_FIGS;
                        tx_char_n   = head.code;
                    end else begin
                        tx_state_n  = TX_CHAR;
                        tx_data_n   = head.code;
                    end
`ifdef UNSHIFT_ON_SPACE_EN
                    if (head.cls == CLS_BOTH && head.code == 5'h04)
                        cur_shift_n = SH_LTRS;
`else
                    // Space leaves the shift state as it was.
`endif
                end
            end
            TX_SHIFT, TX_CHAR: begin
                if (tx_clk == TX_CW'(BAUDOT_CLKS_PER_BIT - 1)) begin
                    tx_clk_n = '0;
                    if (tx_idx == 4'(NBITS - 1)) begin
                        tx_idx_n = '0;
                        // Shift frame runs straight into its character frame.
                        if (tx_state == TX_SHIFT) begin
                            tx_state_n = TX_CHAR;
                            tx_data_n  = tx_char;
                        end else begin
                            tx_state_n = TX_IDLE;
                        end
                    end else begin
                        tx_idx_n = tx_idx + 4'd1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Bit 0 = start, bits 1..5 = code, everything above = stop (mark).
    // The frame length is set by NBITS, so the upper ones cover any stop count.
    assign frame_n = {10'h3FF, tx_data_n, 1'b0};
    assign line_n  = (tx_state_n == TX_IDLE) ? 1'b1 : frame_n[tx_idx_n];

    // ---------------- Outputs ----------------
    assign bus.baudot_tx   = baudot_q;
    assign bus.busy        = (tx_state != TX_IDLE) || (fifo_cnt != 3'd0);
    assign bus.ascii_valid = ascii_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.dropped     = dropped_q;
    assign rx_state_dbg    = rx_state;
    assign tx_state_dbg    = tx_state;
    assign cur_shift_dbg   = cur_shift;

endmodule
